psum_depacketizer_router: RTL and testbench
===========================================

Name: psum_depacketizer_router

Overview:
Clocked, parametrised partial-sum depacketizer for the Psum adder path. Accepts NoC packets on a valid/ready input and extracts the DWIDTH-bit psum from the packet LSBs. Decodes the source-address field and steers each psum into one of NUM_CH per-channel output FIFOs (one per PE queue feeding the adder). Adds buffering, backpressure, a programmable source map and handling of unmatched sources.

Parameters:
DWIDTH, 8, psum width; payload is packet[DWIDTH-1:0]
PWIDTH, 47, packet width
SRC_LSB, 40, LSB of the source-address field in the packet
SWIDTH, 3, source-address field width
NUM_CH, 3, number of output channels
DEPTH, 4, entries per channel FIFO; power of 2, >=2
SRC_MAP, {3'd0,3'd1,3'd3}, NUM_CH*SWIDTH flat vector; slice i = source address routed to channel i (default: src3->ch0, src1->ch1, src0->ch2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input packet valid
in_ready  out  1  input can accept
in_data  in  PWIDTH  packet
out_valid  out  NUM_CH  per-channel psum valid
out_ready  in  NUM_CH  per-channel consumer ready
out_data  out  NUM_CH*DWIDTH  channel i psum at [i*DWIDTH +: DWIDTH]
fifo_count  out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy

Behaviour:
- Reset (async, rst_n=0): hold stage empty, all FIFOs empty, FIFO pointers 0, out_valid=0, out_data=0, fifo_count=0. in_ready=1 while rst_n=1 and hold stage empty. Reset mid-transfer discards all buffered psums; nothing is replayed.
- Input transfer: occurs on a rising edge with in_valid&in_ready. Packet is captured into a 1-entry hold register (psum + decoded channel/match flag).
- Decode: channel = lowest i with SRC_MAP slice i == in_data[SRC_LSB +: SWIDTH]. Duplicate map entries resolve to the lowest index. No match -> unmatched.
- Hold stage drains in the cycle it is valid: matched and target FIFO not full -> push. Unmatched -> discarded. Target full -> hold stalls (head-of-line block, no reordering).
- in_ready = ~hold_valid | hold_drains. This is combinational from registered state only, never from in_valid/in_data. Sustains 1 packet/clk when targets are not full.
- Latency: packet accepted at edge N -> in FIFO at edge N+1 -> out_valid high after edge N+1 (2 edges). No bypass path.
- FIFO: out_valid[i] = count_i != 0; out_data slice = head entry (registered storage). Pop on out_valid[i]&out_ready[i].
- Simultaneous push and pop, not full: count unchanged, both happen. Full: push blocked even if a pop occurs the same cycle; push retries next cycle. Empty: pop ignored.
- Pointers wrap modulo DEPTH. Count range 0..DEPTH.
- Per-channel ordering preserved. Channels are independent; a stalled channel blocks the input only when the hold entry targets it.
- out_data holds its value while out_valid=1 and out_ready=0.

Optional Feature:
Macro DP_ROUTER_UNMATCHED_ERR_EN.
- Defined: adds output err_unmatched (1, sticky, cleared only by reset) and output drop_cnt (16, saturating at 16'hFFFF). Both count/flag each discarded unmatched packet in the cycle it drains.
- Undefined: ports absent; unmatched packets are silently discarded; no extra state.

Test Plan:
- Reset with in_valid=1 -> in_ready=1 once rst_n rises; out_valid=0, fifo_count=0; no packet captured while rst_n=0.
- Packets src=3 psum=8'h11, src=1 psum=8'h22, src=0 psum=8'h33 on consecutive clks, all out_ready=1 -> ch0=11, ch1=22, ch2=33; each out_valid asserts 2 edges after its acceptance.
- Hold out_ready[0]=0; send six src=3 packets -> four accepted into FIFO, fifth held, in_ready=0. Raise out_ready[0] -> drain order 1..6 with no loss.
- Packet src=5 (unmatched) between two src=1 packets -> ch1 receives only the two, no stall. With macro defined: drop_cnt=1, err_unmatched=1.
- Channel 1 full, push and pop in the same cycle -> pop happens, push waits one cycle, count goes 4->3->4.
- Assert rst_n=0 with ch2 holding 3 entries -> immediate out_valid=0, count=0. After release, new src=0 psum=8'h7F appears as the ch2 head.

Source files
------------

// File: rtl/psum_depacketizer_router.sv
// Psum depacketizer: extracts the psum from each NoC packet and steers it by source address into per-channel FIFOs.
// Define DP_ROUTER_UNMATCHED_ERR_EN to add the err_unmatched flag and drop_cnt counter for unmatched packets.
module psum_depacketizer_router #(
    parameter int DWIDTH  = 8,
    parameter int PWIDTH  = 47,
    parameter int SRC_LSB = 40,
    parameter int SWIDTH  = 3,
    parameter int NUM_CH  = 3,
    parameter int DEPTH   = 4,
    parameter logic [NUM_CH*SWIDTH-1:0] SRC_MAP = {3'd0, 3'd1, 3'd3}
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PWIDTH-1:0]                     in_data,
    output logic [NUM_CH-1:0]                     out_valid,
    input  logic [NUM_CH-1:0]                     out_ready,
    output logic [NUM_CH*DWIDTH-1:0]              out_data,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   fifo_count
`ifdef DP_ROUTER_UNMATCHED_ERR_EN
    ,
    output logic                                  err_unmatched,
    output logic [15:0]                           drop_cnt
`endif
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic              dec_match;
    logic [CHW-1:0]    dec_ch;
    logic              hold_valid;
    logic              hold_match;
    logic [CHW-1:0]    hold_ch;
    logic [DWIDTH-1:0] hold_psum;
    logic              hold_drains;
    logic              target_full;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic              unused_in;

    // Descending scan so that duplicate map entries resolve to the lowest channel.
    always_comb begin
        dec_match = 1'b0;
        dec_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (SRC_MAP[i*SWIDTH +: SWIDTH] == in_data[SRC_LSB +: SWIDTH]) begin
                dec_match = 1'b1;
                dec_ch    = CHW'(i);
            end
        end
    end

    assign unused_in = ^in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_match <= 1'b0;
            hold_ch    <= '0;
            hold_psum  <= '0;
        end else if (in_valid && in_ready) begin
            hold_valid <= 1'b1;
            hold_match <= dec_match;
            hold_ch    <= dec_ch;
            hold_psum  <= in_data[DWIDTH-1:0];
        end else if (hold_drains) begin
            hold_valid <= 1'b0;
        end
    end

    // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
    always_comb begin
        target_full = 1'b0;
        push        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hold_ch == CHW'(i)) begin
                target_full = full[i];
                push[i]     = hold_valid & hold_match & ~full[i];
            end
        end
        hold_drains = hold_valid & (~hold_match | ~target_full);
    end

    assign in_ready = rst_n & (~hold_valid | hold_drains);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DWIDTH-1:0] mem [DEPTH];
        logic [PTRW-1:0]   wr_ptr;
        logic [PTRW-1:0]   rd_ptr;
        logic [CNTW-1:0]   count;
        logic              pop;

        assign full[g]                          = (count == FULL_CNT);
        assign out_valid[g]                     = (count != '0);
        assign pop                              = out_valid[g] & out_ready[g];
        assign out_data[g*DWIDTH +: DWIDTH]     = out_valid[g] ? mem[rd_ptr] : '0;
        assign fifo_count[g*CNTW +: CNTW]       = count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNTW'(push[g]) - CNTW'(pop);
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr] <= hold_psum;
            end
        end
    end

`ifdef DP_ROUTER_UNMATCHED_ERR_EN
    logic drop;
    assign drop = hold_valid & ~hold_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unmatched <= 1'b0;
            drop_cnt      <= '0;
        end else if (drop) begin
            err_unmatched <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_psum_depacketizer_router.sv
// Scoreboard bench for psum_depacketizer_router: directed scenarios followed by random traffic against a routing-table model.
module tb_psum_depacketizer_router;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [46:0]  in_data;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [23:0]  out_data;
    logic [8:0]   fifo_count;
`ifdef DP_ROUTER_UNMATCHED_ERR_EN
    logic         err_unmatched;
    logic [15:0]  drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int expDrops = 0;
    logic [7:0] expQ [3][$];

    psum_depacketizer_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count)
`ifdef DP_ROUTER_UNMATCHED_ERR_EN
        ,
        .err_unmatched (err_unmatched),
        .drop_cnt      (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference routing table: source address to channel, -1 when nothing claims it.
    function automatic int routeOf(input logic [2:0] src);
        case (src)
            3'd3:    return 0;
            3'd1:    return 1;
            3'd0:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [46:0] makePacket(input logic [2:0] src, input logic [7:0] psum);
        logic [63:0] r;
        logic [46:0] p;
        r = {$urandom(), $urandom()};
        p = r[46:0];
        p[42:40] = src;
        p[7:0] = psum;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: records accepted packets into the model and checks every popped psum.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && expQ[i].size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL ch%0d_spurious actual=valid(%0h) expected=empty", i, out_data[i*8 +: 8]);
                end else if (out_valid[i] && out_ready[i]) begin
                    checkOutput($sformatf("ch%0d_data", i), 32'(out_data[i*8 +: 8]), 32'(expQ[i].pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                if (routeOf(in_data[42:40]) < 0) begin
                    expDrops++;
                end else begin
                    expQ[routeOf(in_data[42:40])].push_back(in_data[7:0]);
                end
            end
        end
    end

    task automatic waitAccept();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low expected=accept");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] src, input logic [7:0] psum);
        in_data  = makePacket(src, psum);
        in_valid = 1'b1;
        waitAccept();
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout actual=%0d expected=0", expQ[0].size() + expQ[1].size() + expQ[2].size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 3; i++) expQ[i].delete();
        expDrops = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = makePacket(3'd3, 8'hAA);
        out_ready = 3'b111;

        // Reset with a packet offered: nothing may be captured.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("no_capture_valid", 32'(out_valid), 32'd0);
        checkOutput("no_capture_count", 32'(fifo_count), 32'd0);

        // Back-to-back routing with two-edge latency.
        applyStimulus(3'd3, 8'h11);
        checkOutput("lat_edge_n", 32'(out_valid), 32'b000);
        applyStimulus(3'd1, 8'h22);
        checkOutput("lat_ch0_valid", 32'(out_valid), 32'b001);
        checkOutput("lat_ch0_data", 32'(out_data[7:0]), 32'h11);
        applyStimulus(3'd0, 8'h33);
        checkOutput("lat_ch1_valid", 32'(out_valid), 32'b010);
        @(posedge clk);
        #1;
        checkOutput("lat_ch2_valid", 32'(out_valid), 32'b100);
        checkOutput("lat_ch2_data", 32'(out_data[23:16]), 32'h33);
        waitDrain();

        // Channel 0 backpressure: four in FIFO, fifth held, sixth refused.
        out_ready = 3'b110;
        for (int k = 1; k <= 5; k++) applyStimulus(3'd3, 8'(k));
        in_data  = makePacket(3'd3, 8'd6);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_count0", 32'(fifo_count[2:0]), 32'd4);
        checkOutput("stall_head_hold", 32'(out_data[7:0]), 32'd1);
        out_ready[0] = 1'b1;
        waitAccept();
        waitDrain();

        // Unmatched source between two channel 1 packets.
        out_ready = 3'b111;
        applyStimulus(3'd1, 8'hA1);
        applyStimulus(3'd5, 8'h55);
        checkOutput("unmatched_no_stall", 32'(in_ready), 32'd1);
        applyStimulus(3'd1, 8'hA2);
        waitDrain();
        checkOutput("unmatched_count1", 32'(fifo_count[5:3]), 32'd0);
`ifdef DP_ROUTER_UNMATCHED_ERR_EN
        checkOutput("drop_cnt_one", 32'(drop_cnt), 32'd1);
        checkOutput("err_unmatched_set", 32'(err_unmatched), 32'd1);
`endif

        // Full channel 1: a pop frees a slot only on the following cycle.
        out_ready[1] = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(3'd1, 8'(8'h40 + k));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("full1_count", 32'(fifo_count[5:3]), 32'd4);
        checkOutput("full1_in_ready", 32'(in_ready), 32'd0);
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        checkOutput("full1_after_pop", 32'(fifo_count[5:3]), 32'd3);
        @(posedge clk);
        #1;
        checkOutput("full1_after_push", 32'(fifo_count[5:3]), 32'd4);
        out_ready[1] = 1'b1;
        waitDrain();

        // Reset with channel 2 partly full, then a fresh packet becomes the head.
        out_ready[2] = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(3'd0, 8'(8'h60 + k));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre_reset_count2", 32'(fifo_count[8:6]), 32'd3);
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("mid_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_reset_count", 32'(fifo_count), 32'd0);
        in_data  = makePacket(3'd0, 8'h7F);
        in_valid = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        waitAccept();
        @(posedge clk);
        #1;
        checkOutput("post_reset_valid2", 32'(out_valid[2]), 32'd1);
        checkOutput("post_reset_head2", 32'(out_data[23:16]), 32'h7F);
        checkOutput("post_reset_count2", 32'(fifo_count[8:6]), 32'd1);
        out_ready = 3'b111;
        waitDrain();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            out_ready = 3'($urandom_range(7));
            in_valid  = ($urandom_range(3) != 0);
            in_data   = makePacket(3'($urandom_range(7)), 8'($urandom_range(255)));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        waitDrain();
        checkOutput("final_count", 32'(fifo_count), 32'd0);
        checkOutput("final_in_ready", 32'(in_ready), 32'd1);
`ifdef DP_ROUTER_UNMATCHED_ERR_EN
        checkOutput("final_drop_cnt", 32'(drop_cnt), 32'(expDrops));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
